// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout: walks a 32x32 cell grid in the framebuffer RAM and
// re-aligns syncs/DE with the RAM read latency so every output leaves on the same cycle.
module vga_scanout #(
   parameter int H_ACTIVE  = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_ACTIVE  = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int CELL_W    = 20,
   parameter int CELL_H    = 15,
   parameter int GRID_COLS = 32,
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] pixel,
   output logic              hsync,
   output logic              vsync,
   output logic              de,
   output logic              frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HC_W    = $clog2(H_TOTAL);
   localparam int VC_W    = $clog2(V_TOTAL);
   localparam int SX_W    = (CELL_W > 1) ? $clog2(CELL_W) : 1;
   localparam int SY_W    = (CELL_H > 1) ? $clog2(CELL_H) : 1;
   localparam int COL_W   = $clog2(GRID_COLS);
   localparam int ROW_W   = ADDR_W - COL_W;

   localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
   localparam logic [HC_W-1:0] H_ACT      = HC_W'(H_ACTIVE);
   localparam logic [HC_W-1:0] H_ACT_LAST = HC_W'(H_ACTIVE - 1);
   localparam logic [HC_W-1:0] HS_FIRST   = HC_W'(H_ACTIVE + H_FP);
   localparam logic [HC_W-1:0] HS_LAST    = HC_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
   localparam logic [VC_W-1:0] V_ACT      = VC_W'(V_ACTIVE);
   localparam logic [VC_W-1:0] VS_FIRST   = VC_W'(V_ACTIVE + V_FP);
   localparam logic [VC_W-1:0] VS_LAST    = VC_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [SX_W-1:0] SX_LAST    = SX_W'(CELL_W - 1);
   localparam logic [SY_W-1:0] SY_LAST    = SY_W'(CELL_H - 1);

   generate
      if (H_ACTIVE != CELL_W * GRID_COLS) begin : g_chk_h
         $error("vga_scanout: H_ACTIVE must equal CELL_W*GRID_COLS");
      end
      if (V_ACTIVE / CELL_H > 32) begin : g_chk_v
         $error("vga_scanout: V_ACTIVE/CELL_H must not exceed 32");
      end
      if (GRID_COLS != 32) begin : g_chk_cols
         $error("vga_scanout: GRID_COLS must be 32");
      end
      if (ADDR_W != 2 * COL_W) begin : g_chk_addr
         $error("vga_scanout: ADDR_W must hold a 5-bit row and 5-bit column");
      end
   endgenerate

   // Stage 0: position counters and the address/timing registered for that position
   logic [HC_W-1:0]   h_cnt_q, h_cnt_d;
   logic [VC_W-1:0]   v_cnt_q, v_cnt_d;
   logic [SX_W-1:0]   sub_x_q, sub_x_d;
   logic [SY_W-1:0]   sub_y_q, sub_y_d;
   logic [COL_W-1:0]  cell_col_q, cell_col_d;
   logic [ROW_W-1:0]  cell_row_q, cell_row_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              act0_q, act0_d;
   logic              hs0_q, hs0_d;
   logic              vs0_q, vs0_d;
   logic              fs0_q, fs0_d;

   // Stage 1: timing held while the RAM produces its data
   logic              act1_q, hs1_q, vs1_q, fs1_q;

   // Stage 2: outputs
   logic [DATA_W-1:0] pixel_q, pixel_d;
   logic              hsync_q, vsync_q, de_q, fs2_q;

   logic              h_wrap, v_wrap;

   always_comb begin
      h_wrap = (h_cnt_q == H_LAST);
      v_wrap = (v_cnt_q == V_LAST);

      h_cnt_d = h_wrap ? '0 : h_cnt_q + HC_W'(1);
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = v_wrap ? '0 : v_cnt_q + VC_W'(1);
      end

      sub_x_d    = sub_x_q;
      cell_col_d = cell_col_q;
      if (h_wrap) begin
         sub_x_d    = '0;
         cell_col_d = '0;
      end else if (h_cnt_q < H_ACT_LAST) begin
         if (sub_x_q == SX_LAST) begin
            sub_x_d    = '0;
            cell_col_d = cell_col_q + COL_W'(1);
         end else begin
            sub_x_d = sub_x_q + SX_W'(1);
         end
      end

      // Rows step once per finished visible line; the last row wraps back to 0.
      sub_y_d    = sub_y_q;
      cell_row_d = cell_row_q;
      if (h_wrap) begin
         if (v_wrap) begin
            sub_y_d    = '0;
            cell_row_d = '0;
         end else if (v_cnt_q < V_ACT) begin
            if (sub_y_q == SY_LAST) begin
               sub_y_d    = '0;
               cell_row_d = cell_row_q + ROW_W'(1);
            end else begin
               sub_y_d = sub_y_q + SY_W'(1);
            end
         end
      end

      act0_d     = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
      ram_addr_d = act0_d ? {cell_row_d, cell_col_d} : {cell_row_d, {COL_W{1'b0}}};
      hs0_d      = !((h_cnt_d >= HS_FIRST) && (h_cnt_d <= HS_LAST));
      vs0_d      = !((v_cnt_d >= VS_FIRST) && (v_cnt_d <= VS_LAST));
      fs0_d      = (h_cnt_d == '0) && (v_cnt_d == '0);

      pixel_d    = act1_q ? ram_dout : '0;
   end

   // Stage-0 reset values describe position (0,0), so the first pixel emerges
   // two edges after reset is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         sub_x_q    <= '0;
         sub_y_q    <= '0;
         cell_col_q <= '0;
         cell_row_q <= '0;
         ram_addr_q <= '0;
         act0_q     <= 1'b1;
         hs0_q      <= 1'b1;
         vs0_q      <= 1'b1;
         fs0_q      <= 1'b1;
         act1_q     <= 1'b0;
         hs1_q      <= 1'b1;
         vs1_q      <= 1'b1;
         fs1_q      <= 1'b0;
         pixel_q    <= '0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         de_q       <= 1'b0;
         fs2_q      <= 1'b0;
      end else begin
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         sub_x_q    <= sub_x_d;
         sub_y_q    <= sub_y_d;
         cell_col_q <= cell_col_d;
         cell_row_q <= cell_row_d;
         ram_addr_q <= ram_addr_d;
         act0_q     <= act0_d;
         hs0_q      <= hs0_d;
         vs0_q      <= vs0_d;
         fs0_q      <= fs0_d;
         act1_q     <= act0_q;
         hs1_q      <= hs0_q;
         vs1_q      <= vs0_q;
         fs1_q      <= fs0_q;
         pixel_q    <= pixel_d;
         hsync_q    <= hs1_q;
         vsync_q    <= vs1_q;
         de_q       <= act1_q;
         fs2_q      <= fs1_q;
      end
   end

   assign ram_addr    = ram_addr_q;
   assign pixel       = pixel_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign frame_start = fs2_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a scaled-down raster (80x73 total, 64x64 visible,
// 2x2-pixel cells) so whole frames fit in a short run; the 32x32 grid is unchanged.
module tb_vga_scanout;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4;
   localparam int VA = 64, VF = 3, VS = 2, VB = 4;
   localparam int CW = 2,  CH = 2;
   localparam int HT = HA + HF + HS + HB;   // 80
   localparam int VT = VA + VF + VS + VB;   // 73
   localparam int FRAME = HT * VT;          // 5840

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] ram_addr;
   logic [3:0] ram_dout = 4'h0;
   logic [3:0] pixel;
   logic       hsync, vsync, de, frame_start;

   logic [3:0] mem [0:1023];
   int         n = 0;            // edges since reset was last sampled high
   int         compared = 0;
   int         mismatched = 0;
   bit         done = 1'b0;

   vga_scanout #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CELL_W(CW), .CELL_H(CH), .GRID_COLS(32), .ADDR_W(10), .DATA_W(4)
   ) dut (
      .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_dout(ram_dout),
      .pixel(pixel), .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Framebuffer RAM with one-cycle registered read
   always @(posedge clk) begin
      ram_dout <= mem[ram_addr];
      n        <= rst ? 0 : n + 1;
   end

   // Address the raster position p must read: cell = (v/CH, h/CW); blanking reads column 0.
   function automatic logic [9:0] exp_addr(input int p);
      int h, v;
      h = p % HT;
      v = p / HT;
      if (v >= VA) return 10'd0;
      return 10'((v / CH) * 32 + ((h < HA) ? h / CW : 0));
   endfunction

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
   endtask

   // Per-cycle model comparison: outputs show position n-2, ram_addr shows position n.
   always @(negedge clk) begin
      logic [3:0] e_pix;
      logic [9:0] e_addr;
      logic       e_hs, e_vs, e_de, e_fs;
      int         p, h, v;
      if (!done) begin
         e_addr = exp_addr(n % FRAME);
         if (n < 2) begin
            e_pix = 4'h0; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0;
         end else begin
            p = (n - 2) % FRAME;
            h = p % HT;
            v = p / HT;
            e_de  = (h < HA) && (v < VA);
            e_hs  = !((h >= HA + HF) && (h < HA + HF + HS));
            e_vs  = !((v >= VA + VF) && (v < VA + VF + VS));
            e_fs  = (p == 0);
            e_pix = e_de ? mem[exp_addr(p)] : 4'h0;
         end
         compared++;
         if ({ram_addr, pixel, hsync, vsync, de, frame_start} !==
             {e_addr, e_pix, e_hs, e_vs, e_de, e_fs}) begin
            mismatched++;
            $display("FAIL model n=%0d: got addr=%0d pix=%h hs=%b vs=%b de=%b fs=%b, expected addr=%0d pix=%h hs=%b vs=%b de=%b fs=%b",
                     n, ram_addr, pixel, hsync, vsync, de, frame_start,
                     e_addr, e_pix, e_hs, e_vs, e_de, e_fs);
            if (mismatched >= 40) begin
               done = 1'b1;
               summary();
               $finish;
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp_v);
      compared++;
      if (act != exp_v) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
      end
   endtask

   // Advance until the output stage (out=1) or the address stage (out=0) is at (h,v).
   task automatic wait_pos(input bit out, input int h, input int v);
      int k;
      int target;
      k = 0;
      target = v * HT + h;
      while (k <= FRAME + 8 &&
             !(out ? (n >= 2 && (n - 2) % FRAME == target) : (n % FRAME == target))) begin
         step();
         k++;
      end
      if (k > FRAME + 8) begin
         compared++;
         mismatched++;
         $display("FAIL wait_pos(%0d,%0d): got no match in %0d cycles, expected one", h, v, k);
      end
   endtask

   // Starts at output position (0,0) and ends at (0,0) of the next frame.
   task automatic measure_frame(input string tag, input logic all_f);
      int de_cnt, vs_cnt, vs_first, fs_extra, blank_nz, act_bad;
      de_cnt = 0; vs_cnt = 0; vs_first = -1; fs_extra = 0; blank_nz = 0; act_bad = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (de) de_cnt++;
         if (!vsync) begin
            if (vs_first < 0) vs_first = i;
            vs_cnt++;
         end
         if (frame_start && i > 0) fs_extra++;
         if (!de && pixel != 4'h0) blank_nz++;
         if (all_f && de && pixel != 4'hF) act_bad++;
         step();
      end
      chk({tag, "_de_cycles"}, de_cnt, 4096);
      chk({tag, "_vs_low_cycles"}, vs_cnt, 160);
      chk({tag, "_vs_first"}, vs_first, 5360);
      chk({tag, "_fs_extra"}, fs_extra, 0);
      chk({tag, "_blank_pixel_nz"}, blank_nz, 0);
      chk({tag, "_fs_period"}, int'(frame_start), 1);
      if (all_f) chk({tag, "_active_not_f"}, act_bad, 0);
   endtask

   initial begin
      int de_cnt, hs_cnt, hs_first, cnt;
      for (int i = 0; i < 1024; i++) mem[i] = 4'(i);

      // Reset, release, first pixel two cycles later
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rel1_de", int'(de), 0);
      chk("rel1_fs", int'(frame_start), 0);
      chk("rel1_hsync", int'(hsync), 1);
      chk("rel1_pixel", int'(pixel), 0);
      step();
      chk("rel2_de", int'(de), 1);
      chk("rel2_fs", int'(frame_start), 1);
      chk("rel2_pixel", int'(pixel), 0);
      chk("rel2_hsync", int'(hsync), 1);
      chk("rel2_vsync", int'(vsync), 1);
      chk("addr_h2", int'(ram_addr), 1);
      step();
      chk("addr_h3", int'(ram_addr), 1);
      step();
      chk("addr_h4", int'(ram_addr), 2);
      wait_pos(1'b0, 0, 1);
      chk("addr_line1_h0", int'(ram_addr), 0);

      // One line: DE width and hsync placement
      wait_pos(1'b1, 0, 1);
      de_cnt = 0; hs_cnt = 0; hs_first = -1;
      for (int i = 0; i < HT; i++) begin
         if (de) de_cnt++;
         if (!hsync) begin
            if (hs_first < 0) hs_first = i;
            hs_cnt++;
         end
         step();
      end
      chk("line_de_cycles", de_cnt, 64);
      chk("line_hs_low", hs_cnt, 8);
      chk("line_hs_start", hs_first, 68);

      // Full frame timing
      wait_pos(1'b1, 0, 0);
      measure_frame("frame", 1'b0);

      // Change one cell before its rows are scanned, then check the grid corners
      mem[33] = 4'h5;
      wait_pos(1'b0, 0, 2);
      chk("addr_row1", int'(ram_addr), 32);
      wait_pos(1'b1, 2, 2);
      chk("cell33_first", int'(pixel), 5);
      wait_pos(1'b1, 3, 3);
      chk("cell33_last", int'(pixel), 5);
      wait_pos(1'b1, 4, 3);
      chk("cell34", int'(pixel), 2);
      wait_pos(1'b0, 62, 62);
      chk("addr_last_cell_a", int'(ram_addr), 1023);
      wait_pos(1'b0, 63, 63);
      chk("addr_last_pixel", int'(ram_addr), 1023);
      wait_pos(1'b0, 64, 63);
      chk("addr_last_hblank", int'(ram_addr), 992);
      wait_pos(1'b1, 63, 63);
      chk("pixel_last", int'(pixel), 15);
      wait_pos(1'b0, 0, 64);
      chk("addr_vblank", int'(ram_addr), 0);
      wait_pos(1'b0, 0, 0);
      chk("addr_wrap", int'(ram_addr), 0);

      // Mid-frame reset
      wait_pos(1'b1, 30, 20);
      rst = 1'b1;
      step();
      chk("mrst_de", int'(de), 0);
      chk("mrst_fs", int'(frame_start), 0);
      chk("mrst_hsync", int'(hsync), 1);
      chk("mrst_vsync", int'(vsync), 1);
      chk("mrst_pixel", int'(pixel), 0);
      chk("mrst_addr", int'(ram_addr), 0);
      rst = 1'b0;
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!frame_start && cnt < 10);
      chk("mrst_fs_delay", cnt, 2);
      measure_frame("after_rst", 1'b0);

      // Blanking with an all-F framebuffer
      rst = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = 4'hF;
      repeat (2) step();
      rst = 1'b0;
      wait_pos(1'b1, 0, 0);
      measure_frame("fill_f", 1'b1);

      done = 1'b1;
      summary();
      $finish;
   end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Downstream stage of the 1024x4 framebuffer RAM (ram1024). Generates 640x480@60 VGA timing and walks the RAM read address as a 32x32 grid of 20x15-pixel cells. Registers the RAM's 4-bit output as the pixel value. Delays sync and data-enable to match the RAM read latency, so the pixel, syncs and DE leave the block cycle-aligned.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
CELL_W, 20, pixels per cell horizontally
CELL_H, 15, lines per cell vertically
GRID_COLS, 32, cells per row; row stride in RAM words
ADDR_W, 10, RAM address width
DATA_W, 4, RAM data / pixel width

Ports:
clk  in  1  pixel clock (25.175 MHz); single clock domain
rst  in  1  synchronous, active-high reset
ram_addr  out  ADDR_W  read address to framebuffer RAM
ram_dout  in  DATA_W  RAM registered read data, valid 1 cycle after ram_addr is sampled
pixel  out  DATA_W  colour index, forced 0 outside active area
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
de  out  1  data enable, high for visible pixels
frame_start  out  1  one-cycle pulse coincident with output pixel (0,0)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: h_cnt=0, v_cnt=0, all cell counters=0, ram_addr=0, pixel=0, hsync=1, vsync=1, de=0, frame_start=0. All delay-pipe stages are cleared to these inactive values.
- h_cnt counts 0..H_TOTAL-1 (800), then wraps to 0.
- v_cnt increments when h_cnt wraps. v_cnt counts 0..V_TOTAL-1 (525), then wraps to 0.
- Raw timing, stage 0 (registered, from counters):
  - active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE)
  - hs_raw low for h_cnt in [656,751]
  - vs_raw low for v_cnt in [490,491]
- Cell addressing uses counters only; no divider or multiplier.
  - sub_x 0..CELL_W-1 and cell_col 0..31 advance during active h.
  - sub_x, cell_col clear at h_cnt wrap.
  - sub_y 0..CELL_H-1 and cell_row 0..31 advance at the end of each active line.
  - sub_y, cell_row clear at v_cnt wrap.
- ram_addr = {cell_row[4:0], cell_col[4:0]}, registered in the same cycle as h_cnt/v_cnt (stage 0).
  - Outside the active region ram_addr = {cell_row,5'b0}.
  - ram_addr never exceeds 1023.
- Pipeline:
  - Stage 0: counters/ram_addr.
  - Stage 1: RAM registers its data; active/hs/vs delayed one stage.
  - Stage 2: pixel = active_d1 ? ram_dout : 0; hsync, vsync, de, frame_start registered.
- Fixed latency: 2 cycles from counter position to outputs. All outputs are mutually aligned.
- frame_start = 1 exactly when the output stage corresponds to h_cnt=0, v_cnt=0. One pulse per 420000 cycles.
- Wrap-around:
  - Last active pixel (639,479) reads address 1023.
  - Next frame's first pixel reads address 0.
  - No read beyond 1023 occurs.
- Reset mid-frame: the next cycle after rst is sampled high shows reset values on all outputs. Timing restarts at (0,0). The first valid pixel appears 2 cycles after rst deasserts.
- Write-side traffic to the RAM is outside this block. Pixel shows whatever the RAM returns; no coherency handling.
- Parameter legality (elaboration-time checks):
  - H_ACTIVE = CELL_W*GRID_COLS
  - V_ACTIVE/CELL_H <= 32
  - GRID_COLS = 2^5

Test Plan:
1. Reset, then release; RAM model mem[i]=i[3:0]. Response: cycle 2 after release shows de=1, frame_start=1, pixel=0, hsync=1, vsync=1.
2. Count one line. Response: de high for exactly 640 cycles per 800. hsync low for 96 cycles, starting 656 cycles after de rises. ram_addr=0 for h=0..19 and 1 for h=20..39.
3. Run a full frame. Response:
   - 525 lines; vsync low for 1600 cycles beginning at line 490.
   - line 15, h=0 reads addr 32.
   - h=620..639, v=465..479 reads addr 1023.
   - frame_start repeats after exactly 420000 cycles.
4. Blanking check with RAM filled with 4'hF. Response: pixel=0 whenever de=0; pixel=F whenever de=1.
5. Assert rst for 1 cycle at h=300, v=200. Response: outputs return to reset values the next cycle. frame_start fires 2 cycles after deassert. The following frame's timing matches scenario 3.
6. Change mem[33] to 4'h5 mid-frame before line 15 is scanned. Response: output pixels at h=20..39, v=15..29 (output-aligned) equal 5.
